// File: rtl/vending_machine_multi_if.sv
// Bus between the coin acceptor front-end / purchase panel and the vending controller.
//   master: drives coin_in, sel, buy, cancel; observes the dispenser-side outputs.
//   slave : the controller; drives vend_valid, vend_id, change_pulse, coin_reject,
//           err_funds, err_sel, credit, busy.
interface vending_machine_multi_if #(
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned CREDIT_W = 8
);
  logic [1:0]          coin_in;
  logic [SEL_W-1:0]    sel;
  logic                buy;
  logic                cancel;
  logic                vend_valid;
  logic [SEL_W-1:0]    vend_id;
  logic                change_pulse;
  logic                coin_reject;
  logic                err_funds;
  logic                err_sel;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport master (
    output coin_in, sel, buy, cancel,
    input  vend_valid, vend_id, change_pulse, coin_reject, err_funds, err_sel, credit, busy
  );

  modport slave (
    input  coin_in, sel, buy, cancel,
    output vend_valid, vend_id, change_pulse, coin_reject, err_funds, err_sel, credit, busy
  );
endinterface

// File: rtl/vending_machine_multi.sv
// Multi-product coin vending controller.
// Collects coins into a saturating credit, vends one of NUM_PROD products on buy,
// pays change/refunds one CHANGE_UNIT coin per cycle, and auto-refunds after TIMEOUT
// idle cycles in COLLECT.
// Ports:
//   clock   - rising-edge clock
//   reset_n - asynchronous active-low reset
//   bus     - slave side of vending_machine_multi_if (coin/sel/buy/cancel in,
//             vend/change/error pulses, credit and busy out; all outputs registered)
module vending_machine_multi #(
  parameter int unsigned                  NUM_PROD    = 4,
  parameter int unsigned                  CREDIT_W    = 8,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES      = {8'd25, 8'd20, 8'd15, 8'd10},
  parameter int unsigned                  COIN1       = 5,
  parameter int unsigned                  COIN2       = 10,
  parameter int unsigned                  COIN3       = 20,
  parameter int unsigned                  CHANGE_UNIT = 5,
  parameter int unsigned                  MAX_CREDIT  = 50,
  parameter int unsigned                  TIMEOUT     = 200,
  localparam int unsigned                 SEL_W       = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
  input logic                    clock,
  input logic                    reset_n,
  vending_machine_multi_if.slave bus
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [CREDIT_W:0]   MaxCredit = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] Unit      = CREDIT_W'(CHANGE_UNIT);
  localparam logic [TMR_W-1:0]    TmrLast   = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StVend, StChange} state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [SEL_W-1:0]    vend_id_q, vend_id_d;
  logic                vend_q, vend_d;
  logic                change_q, change_d;
  logic                reject_q, reject_d;
  logic                efunds_q, efunds_d;
  logic                esel_q, esel_d;
  logic                busy_q, busy_d;

  logic                coin_present;
  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] price;
  logic                sel_ok;

  always_comb begin
    coin_present = (bus.coin_in != 2'b00);
    case (bus.coin_in)
      2'b01:   coin_val = (CREDIT_W + 1)'(COIN1);
      2'b10:   coin_val = (CREDIT_W + 1)'(COIN2);
      2'b11:   coin_val = (CREDIT_W + 1)'(COIN3);
      default: coin_val = '0;
    endcase
    // One bit wider than credit so the ceiling check cannot wrap.
    sum = {1'b0, credit_q} + coin_val;
  end

  // Price lookup; out-of-range selects leave sel_ok low and price zero.
  always_comb begin
    price  = '0;
    sel_ok = 1'b0;
    for (int i = 0; i < int'(NUM_PROD); i++) begin
      if (bus.sel == SEL_W'(i)) begin
        price  = PRICES[i*CREDIT_W +: CREDIT_W];
        sel_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    tmr_d     = tmr_q;
    vend_id_d = vend_id_q;
    vend_d    = 1'b0;
    change_d  = 1'b0;
    reject_d  = 1'b0;
    efunds_d  = 1'b0;
    esel_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.buy) begin
          // No credit yet, so any valid product is unaffordable.
          reject_d = coin_present;
          esel_d   = !sel_ok;
          efunds_d = sel_ok;
        end else if (coin_present) begin
          if (coin_val <= MaxCredit) begin
            credit_d = coin_val[CREDIT_W-1:0];
            tmr_d    = '0;
            state_d  = StCollect;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      StCollect: begin
        if (bus.cancel) begin
          reject_d = coin_present;
          state_d  = StChange;
        end else if (bus.buy) begin
          reject_d = coin_present;
          tmr_d    = '0;
          if (!sel_ok) begin
            esel_d = 1'b1;
          end else if (credit_q < price) begin
            efunds_d = 1'b1;
          end else begin
            credit_d  = credit_q - price;
            vend_id_d = bus.sel;
            vend_d    = 1'b1;
            state_d   = StVend;
          end
        end else if (coin_present && (sum <= MaxCredit)) begin
          credit_d = sum[CREDIT_W-1:0];
          tmr_d    = '0;
        end else begin
          reject_d = coin_present;
          if (tmr_q == TmrLast) begin
            state_d = StChange;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
      end
      StVend, StChange: begin
        // The VEND cycle already pays the first change coin, so a purchase with
        // change shows its first change_pulse on the cycle after vend_valid.
        reject_d = coin_present;
        if (credit_q != '0) begin
          credit_d = credit_q - Unit;
          change_d = 1'b1;
          state_d  = StChange;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StVend) || (state_d == StChange);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      credit_q  <= '0;
      tmr_q     <= '0;
      vend_id_q <= '0;
      vend_q    <= 1'b0;
      change_q  <= 1'b0;
      reject_q  <= 1'b0;
      efunds_q  <= 1'b0;
      esel_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      tmr_q     <= tmr_d;
      vend_id_q <= vend_id_d;
      vend_q    <= vend_d;
      change_q  <= change_d;
      reject_q  <= reject_d;
      efunds_q  <= efunds_d;
      esel_q    <= esel_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.vend_valid   = vend_q;
  assign bus.vend_id      = vend_id_q;
  assign bus.change_pulse = change_q;
  assign bus.coin_reject  = reject_q;
  assign bus.err_funds    = efunds_q;
  assign bus.err_sel      = esel_q;
  assign bus.credit       = credit_q;
  assign bus.busy         = busy_q;

endmodule
